spi_ram_bridge: RTL and testbench
=================================

# spi_ram_bridge

Byte-level command engine between the SPI slave shift register and the SPI-side port of the RAM multiplexer. It decodes a framed byte stream (write/read commands, 5-bit word address, 32-bit big-endian payload) and generates the RAM strobe sequence (clock pulse, write enable, address, data) that the multiplexer forwards to the RAM while the core is halted and SPI is selected. Addresses auto-increment for burst transfers; read data is prefetched so the next outgoing SPI byte is always ready.

## Interface
Parameters:
- ADDR_W, 5, RAM word-address width
- DATA_W, 32, RAM word width; must be 32 (4 bytes per word)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- cs_i  in  1  SPI frame active (already synchronised to clk_i); high = frame open
- rx_valid_i  in  1  one-cycle pulse: rx_byte_i holds a complete received byte
- rx_byte_i  in  8  received byte
- tx_byte_o  out  8  byte the SPI slave shifts out at the next byte boundary
- mem_clk_o  out  1  RAM clock pulse, to multiplexer SPI clock input
- mem_we_o  out  1  RAM write enable, to multiplexer SPI write-enable input
- mem_addr_o  out  ADDR_W  RAM word address
- mem_data_o  out  DATA_W  RAM write data
- mem_data_i  in  DATA_W  RAM read data from multiplexer
- busy_o  out  1  RAM access sequence in progress
- err_o  out  1  unknown command seen in current/last frame

## Operation
- Frame protocol (all bytes MSB-first, words big-endian): byte0 = command, byte1 = start address (bits [ADDR_W-1:0] used, upper bits ignored), then payload bytes.
- 0x02 WRITE: every 4 payload bytes form one word; after the 4th byte a write access is issued to the current address, then address increments.
- 0x03 READ: after the address byte a read access is issued immediately (prefetch); tx_byte_o presents byte3 (MSB) of the word, then advances one byte per rx_valid_i (dummy bytes ignored); after the 4th byte address increments and the next word is prefetched.
- Any other command: err_o = 1, remaining bytes ignored until cs_i falls.
- Address wrap: 31 increments to 0; no error.
- States: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE; access sub-sequence SETUP, STROBE, HOLD, CAPTURE (read only).
- IDLE -> CMD on cs_i rise; CMD -> ADDR/IGNORE on first byte; ADDR -> WDATA or (access, then RDATA); cs_i low from any state -> IDLE, except an in-flight access completes first.
- Partial word (fewer than 4 bytes) at cs_i fall: discarded, no write.
- Payload bytes are assembled in a separate shift register; a byte arriving during an access is still captured.
- err_o cleared on cs_i rise; set in CMD on unknown command; held otherwise.

## Timing
- Access, issue cycle N: SETUP (mem_addr_o, mem_data_o, mem_we_o driven, mem_clk_o = 0, busy_o = 1); N+1 STROBE mem_clk_o = 1; N+2 HOLD mem_clk_o = 0, mem_we_o still valid; N+3 write: mem_we_o = 0, busy_o = 0; read: CAPTURE samples mem_data_i, tx_byte_o updated at N+4, busy_o = 0.
- Addr/data/we stable from SETUP through HOLD; mem_clk_o high exactly one clk_i cycle per access.
- tx_byte_o updates on the cycle after rx_valid_i.
- Requirement on integrator: rx_valid_i spacing >= 8 clk_i cycles (guaranteed by SPI clock <= clk_i/2).
- Reset values: tx_byte_o 0x00, mem_clk_o 0, mem_we_o 0, mem_addr_o 0, mem_data_o 0, busy_o 0, err_o 0, state IDLE. Reset mid-access aborts immediately (mem_clk_o low next edge).

## Configuration
- SPI_RAM_READ_EN defined: 0x03 READ supported as above.
- Not defined: READ logic (prefetch, CAPTURE, tx byte mux) removed; 0x03 treated as unknown (err_o = 1); tx_byte_o constant 0x00.

## Test plan
- Frame 02,05,DE,AD,BE,EF,01,02,03,04 -> two writes: addr 5 = 0xDEADBEEF, addr 6 = 0x01020304; mem_clk_o one-cycle high each, mem_we_o 1 through HOLD.
- Frame 02,1F,8 bytes -> writes to addr 31 then addr 0 (wrap).
- Preloaded RAM addr 3 = 0xCAFEF00D, frame 03,03,4 dummies -> tx_byte_o CA,FE,F0,0D; prefetch of addr 4 follows; mem_we_o never high.
- Frame 02,00,11,22,33 then cs_i low -> no access, state IDLE.
- Frame 7A,... -> err_o = 1, no access; next frame cs_i rise clears err_o.
- rst_i asserted during STROBE -> next edge mem_clk_o 0, all outputs at reset values; without SPI_RAM_READ_EN, frame 03 -> err_o = 1.

Source files
------------

// File: rtl/spi_ram_bridge_if.sv
// Bundle between the SPI byte engine (spi_ram_bridge) and its surroundings.
// The SPI slave byte stream and the RAM multiplexer port share one interface.
interface spi_ram_bridge_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cs_i;
  logic              rx_valid_i;
  logic [7:0]        rx_byte_i;
  logic [7:0]        tx_byte_o;
  logic              mem_clk_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              busy_o;
  logic              err_o;

  // The bridge itself.
  modport slave (
    input  cs_i, rx_valid_i, rx_byte_i, mem_data_i,
    output tx_byte_o, mem_clk_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, err_o
  );

  // The SPI slave / RAM multiplexer side.
  modport master (
    output cs_i, rx_valid_i, rx_byte_i, mem_data_i,
    input  tx_byte_o, mem_clk_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, err_o
  );
endinterface

// File: rtl/spi_ram_bridge.sv
// SPI byte-stream command engine driving the SPI-side RAM strobe port.
// Define SPI_RAM_READ_EN to add the 0x03 READ command with word prefetch.
module spi_ram_bridge #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  spi_ram_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
  } state_e;

  typedef enum logic [2:0] {
    A_IDLE, A_SETUP, A_STROBE, A_HOLD, A_CAPTURE
  } acc_e;

  localparam logic [7:0] CMD_WRITE = 8'h02;
`ifdef SPI_RAM_READ_EN
  localparam logic [7:0] CMD_READ  = 8'h03;
`endif

  state_e            state_q, state_d;
  acc_e              acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              err_q, err_d;
  logic              acc_we_q, acc_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
`ifdef SPI_RAM_READ_EN
  logic              is_rd_q, is_rd_d;
  logic [DATA_W-1:0] rd_word_q, rd_word_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
`endif

  logic              start;
  logic              start_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] wword;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    err_d      = err_q;
    acc_we_d   = acc_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
`ifdef SPI_RAM_READ_EN
    is_rd_d    = is_rd_q;
    rd_word_d  = rd_word_q;
    tx_byte_d  = tx_byte_q;
`endif
    start      = 1'b0;
    start_we   = 1'b0;
    issue_addr = addr_q;
    wword      = {shift_q[DATA_W-9:0], bus.rx_byte_i};

    case (state_q)
      S_IDLE: begin
        if (bus.cs_i) begin
          state_d = S_CMD;
          err_d   = 1'b0;
          cnt_d   = 2'd0;
        end
      end
      S_CMD: begin
        if (bus.rx_valid_i) begin
          if (bus.rx_byte_i == CMD_WRITE) begin
            state_d = S_ADDR;
`ifdef SPI_RAM_READ_EN
            is_rd_d = 1'b0;
          end else if (bus.rx_byte_i == CMD_READ) begin
            state_d = S_ADDR;
            is_rd_d = 1'b1;
`endif
          end else begin
            state_d = S_IGNORE;
            err_d   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (bus.rx_valid_i) begin
          cnt_d = 2'd0;
`ifdef SPI_RAM_READ_EN
          if (is_rd_q) begin
            // Prefetch the first word so its MSB is ready before the first dummy byte.
            state_d    = S_RDATA;
            start      = 1'b1;
            issue_addr = bus.rx_byte_i[ADDR_W-1:0];
            addr_d     = bus.rx_byte_i[ADDR_W-1:0] + 1'b1;
          end else begin
            state_d = S_WDATA;
            addr_d  = bus.rx_byte_i[ADDR_W-1:0];
          end
`else
          state_d = S_WDATA;
          addr_d  = bus.rx_byte_i[ADDR_W-1:0];
`endif
        end
      end
      S_WDATA: begin
        if (bus.rx_valid_i) begin
          shift_d = wword;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            start    = 1'b1;
            start_we = 1'b1;
            addr_d   = addr_q + 1'b1;
          end
        end
      end
      S_RDATA: begin
`ifdef SPI_RAM_READ_EN
        if (bus.rx_valid_i) begin
          if (cnt_q == 2'd3) begin
            // Word exhausted: the next MSB arrives with the capture of this prefetch.
            cnt_d  = 2'd0;
            start  = 1'b1;
            addr_d = addr_q + 1'b1;
          end else begin
            cnt_d     = cnt_q + 2'd1;
            rd_word_d = rd_word_q << 8;
            tx_byte_d = rd_word_q[DATA_W-9 -: 8];
          end
        end
`endif
      end
      default: ;
    endcase

    // Frame end returns to IDLE, but never while an access is still on the RAM port.
    if (!bus.cs_i && state_q != S_IDLE && acc_q == A_IDLE) begin
      state_d = S_IDLE;
    end

    // Issue only from A_IDLE; byte spacing guarantees the previous access is done.
    case (acc_q)
      A_IDLE: begin
        if (start) begin
          acc_d      = A_SETUP;
          acc_we_d   = start_we;
          mem_addr_d = issue_addr;
          if (start_we) begin
            mem_data_d = wword;
          end
        end
      end
      A_SETUP:  acc_d = A_STROBE;
      A_STROBE: acc_d = A_HOLD;
      A_HOLD: begin
`ifdef SPI_RAM_READ_EN
        acc_d = acc_we_q ? A_IDLE : A_CAPTURE;
`else
        acc_d = A_IDLE;
`endif
      end
      A_CAPTURE: begin
`ifdef SPI_RAM_READ_EN
        rd_word_d = bus.mem_data_i;
        tx_byte_d = bus.mem_data_i[DATA_W-1 -: 8];
`endif
        acc_d = A_IDLE;
      end
      default: acc_d = A_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      acc_q      <= A_IDLE;
      addr_q     <= '0;
      cnt_q      <= 2'd0;
      shift_q    <= '0;
      err_q      <= 1'b0;
      acc_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
`ifdef SPI_RAM_READ_EN
      is_rd_q    <= 1'b0;
      rd_word_q  <= '0;
      tx_byte_q  <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
      acc_we_q   <= acc_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
`ifdef SPI_RAM_READ_EN
      is_rd_q    <= is_rd_d;
      rd_word_q  <= rd_word_d;
      tx_byte_q  <= tx_byte_d;
`endif
    end
  end

  assign bus.mem_clk_o  = (acc_q == A_STROBE);
  assign bus.busy_o     = (acc_q == A_SETUP) || (acc_q == A_STROBE) || (acc_q == A_HOLD);
  assign bus.mem_we_o   = bus.busy_o && acc_we_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_data_o = mem_data_q;
  assign bus.err_o      = err_q;

`ifdef SPI_RAM_READ_EN
  assign bus.tx_byte_o = tx_byte_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^bus.mem_data_i;
  assign bus.tx_byte_o  = 8'h00;
`endif

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Scoreboard bench for spi_ram_bridge: expected RAM accesses and tx bytes are
// queued as frames are driven and compared as the bridge produces them.
module tb_spi_ram_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_ram_bridge_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  spi_ram_bridge #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // RAM behind the multiplexer: write on the strobe, combinational read.
  logic [31:0] ram [32];
  always @(posedge bus.mem_clk_o) begin
    if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_data_o;
  end
  assign bus.mem_data_i = ram[bus.mem_addr_o];

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } acc_t;

  acc_t       acc_q [$];
  logic [7:0] tx_q  [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Access monitor: one strobe per queued access, we/addr held through HOLD.
  logic       prev_clk = 1'b0;
  logic       hold_chk = 1'b0;
  logic       hold_we  = 1'b0;
  logic [4:0] hold_addr = '0;
  always @(negedge clk) begin : mon
    acc_t e;
    if (hold_chk && !rst) begin
      check("hold_clk_low", bus.mem_clk_o, 0);
      check("hold_we", bus.mem_we_o, hold_we);
      check("hold_addr", bus.mem_addr_o, hold_addr);
    end
    hold_chk <= 1'b0;
    if (bus.mem_clk_o) begin
      check("strobe_single_cycle", prev_clk, 0);
      check("access_expected", acc_q.size() != 0, 1);
      if (acc_q.size() != 0) begin
        e = acc_q.pop_front();
        check("acc_we", bus.mem_we_o, e.we);
        check("acc_addr", bus.mem_addr_o, e.addr);
        if (e.we) check("acc_data", bus.mem_data_o, e.data);
      end
      hold_chk  <= 1'b1;
      hold_we   <= bus.mem_we_o;
      hold_addr <= bus.mem_addr_o;
    end
    prev_clk <= bus.mem_clk_o;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte_i  = b;
    bus.rx_valid_i = 1'b1;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_acc(input logic we, input logic [4:0] a, input logic [31:0] d);
    acc_t e;
    e.we = we; e.addr = a; e.data = d;
    acc_q.push_back(e);
  endtask

  task automatic cs_open();
    @(negedge clk);
    bus.cs_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_close();
    @(negedge clk);
    bus.cs_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},   bus.tx_byte_o, 0);
    check({tag, "_clk"},  bus.mem_clk_o, 0);
    check({tag, "_we"},   bus.mem_we_o, 0);
    check({tag, "_addr"}, bus.mem_addr_o, 0);
    check({tag, "_data"}, bus.mem_data_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_err"},  bus.err_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs_i       = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_byte_i  = 8'h00;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Burst write with cycle-exact strobe timing on the first word.
    cs_open();
    send_byte(8'h02);
    send_byte(8'h05);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    push_acc(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    bus.rx_byte_i  = 8'hEF;
    bus.rx_valid_i = 1'b1;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    check("setup_busy", bus.busy_o, 1);
    check("setup_clk", bus.mem_clk_o, 0);
    check("setup_we", bus.mem_we_o, 1);
    check("setup_addr", bus.mem_addr_o, 5);
    check("setup_data", bus.mem_data_o, 32'hDEADBEEF);
    @(negedge clk);
    check("strobe_clk", bus.mem_clk_o, 1);
    check("strobe_busy", bus.busy_o, 1);
    @(negedge clk);
    check("hold_clk", bus.mem_clk_o, 0);
    check("hold_we_main", bus.mem_we_o, 1);
    check("hold_busy", bus.busy_o, 1);
    @(negedge clk);
    check("done_we", bus.mem_we_o, 0);
    check("done_busy", bus.busy_o, 0);
    repeat (6) @(negedge clk);
    push_acc(1'b1, 5'd6, 32'h01020304);
    send_word(32'h01020304);
    cs_close();
    check("ram5", ram[5], 32'hDEADBEEF);
    check("ram6", ram[6], 32'h01020304);

    // Address wrap 31 -> 0.
    cs_open();
    push_acc(1'b1, 5'd31, 32'hA5A50031);
    push_acc(1'b1, 5'd0,  32'h5A5A0000);
    send_byte(8'h02);
    send_byte(8'h1F);
    send_word(32'hA5A50031);
    send_word(32'h5A5A0000);
    cs_close();
    check("ram31", ram[31], 32'hA5A50031);
    check("ram0", ram[0], 32'h5A5A0000);

    // Partial word at frame end is discarded; next frame starts clean.
    cs_open();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    cs_close();
    check("partial_no_access", acc_q.size(), 0);
    check("partial_busy", bus.busy_o, 0);
    check("partial_ram0", ram[0], 32'h5A5A0000);
    cs_open();
    push_acc(1'b1, 5'd7, 32'hAABBCCDD);
    send_byte(8'h02);
    send_byte(8'h07);
    send_word(32'hAABBCCDD);
    cs_close();
    check("ram7", ram[7], 32'hAABBCCDD);

    // Preload addresses 3 and 4 for the read frame.
    cs_open();
    push_acc(1'b1, 5'd3, 32'hCAFEF00D);
    push_acc(1'b1, 5'd4, 32'h5A6B7C8D);
    send_byte(8'h02);
    send_byte(8'h03);
    send_word(32'hCAFEF00D);
    send_word(32'h5A6B7C8D);
    cs_close();

`ifdef SPI_RAM_READ_EN
    cs_open();
    push_acc(1'b0, 5'd3, 32'h0);
    push_acc(1'b0, 5'd4, 32'h0);
    tx_q.push_back(8'hCA);
    tx_q.push_back(8'hFE);
    tx_q.push_back(8'hF0);
    tx_q.push_back(8'h0D);
    tx_q.push_back(8'h5A);
    send_byte(8'h03);
    send_byte(8'h03);
    check("read_tx0", bus.tx_byte_o, tx_q.pop_front());
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'h00);
      check($sformatf("read_tx%0d", i), bus.tx_byte_o, tx_q.pop_front());
    end
    check("read_err", bus.err_o, 0);
    cs_close();
`else
    cs_open();
    send_byte(8'h03);
    check("read_disabled_err", bus.err_o, 1);
    send_byte(8'h03);
    send_byte(8'h00);
    check("read_disabled_tx", bus.tx_byte_o, 0);
    cs_close();
    check("read_disabled_no_access", acc_q.size(), 0);
`endif

    // Unknown command: error, no access, held after frame, cleared on next frame.
    cs_open();
    check("err_cleared_on_open", bus.err_o, 0);
    send_byte(8'h7A);
    check("bad_cmd_err", bus.err_o, 1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h01020304);
    check("bad_cmd_no_access", acc_q.size(), 0);
    cs_close();
    check("err_held", bus.err_o, 1);
    cs_open();
    check("err_cleared", bus.err_o, 0);
    cs_close();

    // Reset clears a latched error.
    cs_open();
    send_byte(8'h7A);
    cs_close();
    check("err_before_rst", bus.err_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_after_rst", bus.err_o, 0);

    // Reset during STROBE aborts the access at the next edge.
    cs_open();
    push_acc(1'b1, 5'd9, 32'h12345678);
    send_byte(8'h02);
    send_byte(8'h09);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    @(negedge clk);
    bus.rx_byte_i  = 8'h78;
    bus.rx_valid_i = 1'b1;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    check("pre_rst_strobe", bus.mem_clk_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_strobe");
    @(negedge clk);
    rst = 1'b0;
    cs_close();

    check("acc_queue_drained", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
